// File: rtl/vde_sprite_renderer.sv
// Sprite row renderer: fetches one 8-pixel tile row per accepted map entry and
// streams it MSB-first as 1-bit pixels, with a one-row buffer for gapless output.
module vde_sprite_renderer #(
    parameter int MAP_WIDTH = 80
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        frame_start,
    input  logic        sprite_valid_i,
    output logic        sprite_ready_o,
    input  logic [8:0]  sprite_data_i,
    input  logic [3:0]  sprite_row_i,
    output logic [11:0] tile_mem_addr_o,
    output logic        tile_mem_fetch_o,
    input  logic [7:0]  tile_mem_data_i,
    input  logic        tile_mem_done_i,
    output logic        pixel_valid_o,
    input  logic        pixel_ready_i,
    output logic        pixel_o,
    output logic        pixel_eol_o,
    output logic        dbg_state_o
);

    localparam int COL_W = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } fetch_state_t;

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;

    logic [COL_W-1:0] r_col;
    logic             r_eol_tag;
    logic [11:0]      r_addr;
    logic [7:0]       r_buf_data;
    logic             r_buf_full;
    logic             r_buf_eol;
    logic [7:0]       r_shift_reg;
    logic [2:0]       r_bit_cnt;
    logic             r_shift_valid;
    logic             r_shift_eol;

    logic             w_fetch;
    logic             w_sprite_hs;
    logic             w_done_hs;
    logic             w_pix_hs;
    logic             w_last_bit;
    logic             w_load;

    // Handshakes transfer on a rising edge where valid and ready are both high;
    // frame_start on that edge cancels any sprite or memory transfer.
    assign w_fetch        = (r_state == S_FETCH);
    assign sprite_ready_o = ~w_fetch & ~r_buf_full;
    assign w_sprite_hs    = sprite_valid_i & sprite_ready_o & ~frame_start;
    assign w_done_hs      = w_fetch & tile_mem_done_i;
    assign w_pix_hs       = r_shift_valid & pixel_ready_i;
    assign w_last_bit     = (r_bit_cnt == 3'd7);
    assign w_load         = r_buf_full & (~r_shift_valid | (w_pix_hs & w_last_bit));

    assign tile_mem_fetch_o = w_fetch;
    assign tile_mem_addr_o  = r_addr;
    assign pixel_valid_o    = r_shift_valid;
    assign pixel_o          = r_shift_reg[7];
    assign pixel_eol_o      = r_shift_valid & r_shift_eol & w_last_bit;
    assign dbg_state_o      = r_state;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_sprite_hs) w_state_nxt = S_FETCH;
            S_FETCH: if (tile_mem_done_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (frame_start) begin
            w_state_nxt = S_IDLE;
        end
    end

    // The eol tag travels with the row so it survives buffering and stalls.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_col     <= '0;
            r_eol_tag <= 1'b0;
            r_addr    <= '0;
        end else if (frame_start) begin
            r_col <= '0;
        end else if (w_sprite_hs) begin
            r_addr    <= {sprite_data_i, sprite_row_i[2:0]};
            r_eol_tag <= (r_col == COL_LAST);
            r_col     <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_buf_data <= '0;
            r_buf_full <= 1'b0;
            r_buf_eol  <= 1'b0;
        end else if (frame_start) begin
            r_buf_full <= 1'b0;
        end else if (w_done_hs) begin
            r_buf_data <= tile_mem_data_i;
            r_buf_full <= 1'b1;
            r_buf_eol  <= r_eol_tag;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_shift_reg   <= '0;
            r_bit_cnt     <= '0;
            r_shift_valid <= 1'b0;
            r_shift_eol   <= 1'b0;
        end else if (frame_start) begin
            r_bit_cnt     <= '0;
            r_shift_valid <= 1'b0;
        end else if (w_load) begin
            r_shift_reg   <= r_buf_data;
            r_shift_eol   <= r_buf_eol;
            r_bit_cnt     <= '0;
            r_shift_valid <= 1'b1;
        end else if (w_pix_hs) begin
            if (w_last_bit) begin
                r_shift_valid <= 1'b0;
            end else begin
                r_shift_reg <= {r_shift_reg[6:0], 1'b0};
                r_bit_cnt   <= r_bit_cnt + 3'd1;
            end
        end
    end

endmodule
